// File: rtl/vector_alu_pkg.sv
// Shared constants for the vector ALU: primary opcode, function codes, lane widths.
package vector_alu_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CODE_W = 6;

  localparam logic [CODE_W-1:0] OP_VECTOR = 6'b101010;

  localparam logic [CODE_W-1:0] FN_VAND   = 6'b000001;
  localparam logic [CODE_W-1:0] FN_VOR    = 6'b000010;
  localparam logic [CODE_W-1:0] FN_VXOR   = 6'b000011;
  localparam logic [CODE_W-1:0] FN_VNOT   = 6'b000100;
  localparam logic [CODE_W-1:0] FN_VMOV   = 6'b000101;
  localparam logic [CODE_W-1:0] FN_VADD   = 6'b000110;
  localparam logic [CODE_W-1:0] FN_VSUB   = 6'b000111;
  localparam logic [CODE_W-1:0] FN_VMULEU = 6'b001000;
  localparam logic [CODE_W-1:0] FN_VMULOU = 6'b001001;
  localparam logic [CODE_W-1:0] FN_VSLL   = 6'b001010;
  localparam logic [CODE_W-1:0] FN_VSRL   = 6'b001011;
  localparam logic [CODE_W-1:0] FN_VSRA   = 6'b001100;
  localparam logic [CODE_W-1:0] FN_VRTTH  = 6'b001101;
  localparam logic [CODE_W-1:0] FN_VDIV   = 6'b001110;
  localparam logic [CODE_W-1:0] FN_VMOD   = 6'b001111;
  localparam logic [CODE_W-1:0] FN_VSQEU  = 6'b010000;
  localparam logic [CODE_W-1:0] FN_VSQOU  = 6'b010001;
  localparam logic [CODE_W-1:0] FN_VSQRT  = 6'b010010;

  localparam logic [1:0] W8  = 2'b00;
  localparam logic [1:0] W16 = 2'b01;
  localparam logic [1:0] W32 = 2'b10;
  localparam logic [1:0] W64 = 2'b11;

endpackage

// File: rtl/vector_alu_isqrt.sv
// Combinational 64-bit floor integer square root (digit-by-digit, two radicand bits per step).
module vector_alu_isqrt (
  input  logic [63:0] radicand,
  output logic [31:0] root_c
);

  // Remainder never exceeds 2*root+1 before the shift, so 36 bits are enough.
  logic [35:0] rem;
  logic [35:0] trial;
  logic [31:0] root;

  // One result bit per iteration, MSB first.
  always_comb begin
    rem   = '0;
    trial = '0;
    root  = '0;
    for (int i = 31; i >= 0; i--) begin
      rem   = {rem[33:0], radicand[2*i+1 -: 2]};
      trial = {2'b00, root, 2'b01};
      if (rem >= trial) begin
        rem  = rem - trial;
        root = {root[30:0], 1'b1};
      end else begin
        root = {root[30:0], 1'b0};
      end
    end
    root_c = root;
  end

endmodule

// File: rtl/vector_alu.sv
// Registered 64-bit SIMD integer ALU: lane-wise vector ops over 8/16/32/64-bit lanes.
// Lane 0 is the most-significant lane, so in pair ops the even lane is the upper half.
module vector_alu
  import vector_alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rA_64bit_val,
  input  logic [DATA_W-1:0] rB_64bit_val,
  input  logic [5:0]        R_ins,
  input  logic [5:0]        Op_code,
  input  logic [1:0]        WW,
  output logic [DATA_W-1:0] ALU_out
);

  logic [DATA_W-1:0] lane_sel_c;
  logic [DATA_W-1:0] pair_sel_c;
  logic [DATA_W-1:0] result_c;

  for (genvar g = 0; g < 4; g++) begin : g_width
    localparam int unsigned W  = 8 << g;
    localparam int unsigned NL = DATA_W / W;
    localparam int unsigned SW = 3 + g;

    wire [DATA_W-1:0] res_w;
    wire [DATA_W-1:0] pair_w;

    for (genvar l = 0; l < NL; l++) begin : g_lane
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] lane_c;
      logic [31:0]  root_c;

      assign a = rA_64bit_val[l*W +: W];
      assign b = rB_64bit_val[l*W +: W];

      vector_alu_isqrt u_isqrt (
        .radicand (64'(a)),
        .root_c   (root_c)
      );

      // Per-lane arithmetic, shift, rotate, divide and square root.
      always_comb begin
        lane_c = '0;
        case (R_ins)
          FN_VADD:  lane_c = a + b;
          FN_VSUB:  lane_c = a - b;
          FN_VSLL:  lane_c = a << b[SW-1:0];
          FN_VSRL:  lane_c = a >> b[SW-1:0];
          FN_VSRA:  lane_c = W'($signed(a) >>> b[SW-1:0]);
          FN_VRTTH: lane_c = {a[W/2-1:0], a[W-1:W/2]};
          FN_VDIV:  lane_c = (b == '0) ? '0 : a / b;
          FN_VMOD:  lane_c = (b == '0) ? '0 : a % b;
          FN_VSQRT: lane_c = W'(root_c);
          default:  lane_c = '0;
        endcase
      end

      assign res_w[l*W +: W] = lane_c;
    end

    if (g < 3) begin : g_pairs
      for (genvar p = 0; p < NL / 2; p++) begin : g_pair
        logic [W-1:0]   a_even;
        logic [W-1:0]   a_odd;
        logic [W-1:0]   b_even;
        logic [W-1:0]   b_odd;
        logic [2*W-1:0] prod_c;

        assign a_even = rA_64bit_val[p*2*W + W +: W];
        assign a_odd  = rA_64bit_val[p*2*W +: W];
        assign b_even = rB_64bit_val[p*2*W + W +: W];
        assign b_odd  = rB_64bit_val[p*2*W +: W];

        // Double-width product or square filling the even/odd lane pair.
        always_comb begin
          prod_c = '0;
          case (R_ins)
            FN_VMULEU: prod_c = (2*W)'(a_even) * (2*W)'(b_even);
            FN_VMULOU: prod_c = (2*W)'(a_odd)  * (2*W)'(b_odd);
            FN_VSQEU:  prod_c = (2*W)'(a_even) * (2*W)'(a_even);
            FN_VSQOU:  prod_c = (2*W)'(a_odd)  * (2*W)'(a_odd);
            default:   prod_c = '0;
          endcase
        end

        assign pair_w[p*2*W +: 2*W] = prod_c;
      end
    end else begin : g_no_pairs
      assign pair_w = '0;
    end
  end

  // Pick the lane-wise and pair-wise results for the requested width.
  always_comb begin
    lane_sel_c = g_width[0].res_w;
    pair_sel_c = g_width[0].pair_w;
    case (WW)
      W8:  begin lane_sel_c = g_width[0].res_w; pair_sel_c = g_width[0].pair_w; end
      W16: begin lane_sel_c = g_width[1].res_w; pair_sel_c = g_width[1].pair_w; end
      W32: begin lane_sel_c = g_width[2].res_w; pair_sel_c = g_width[2].pair_w; end
      W64: begin lane_sel_c = g_width[3].res_w; pair_sel_c = g_width[3].pair_w; end
      default: begin lane_sel_c = '0; pair_sel_c = '0; end
    endcase
  end

  // Function decode; anything but a known vector R-type op yields zero.
  always_comb begin
    result_c = '0;
    if (Op_code == OP_VECTOR) begin
      case (R_ins)
        FN_VAND:  result_c = rA_64bit_val & rB_64bit_val;
        FN_VOR:   result_c = rA_64bit_val | rB_64bit_val;
        FN_VXOR:  result_c = rA_64bit_val ^ rB_64bit_val;
        FN_VNOT:  result_c = ~rA_64bit_val;
        FN_VMOV:  result_c = rA_64bit_val;
        FN_VADD, FN_VSUB, FN_VSLL, FN_VSRL, FN_VSRA,
        FN_VRTTH, FN_VDIV, FN_VMOD, FN_VSQRT:
                  result_c = lane_sel_c;
        FN_VMULEU, FN_VMULOU, FN_VSQEU, FN_VSQOU:
                  result_c = pair_sel_c;
        default:  result_c = '0;
      endcase
    end
  end

  // Result register; reset wins over any operation presented on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ALU_out <= '0;
    end else begin
      ALU_out <= result_c;
    end
  end

endmodule

// File: tb/tb_vector_alu.sv
// Directed self-checking bench for vector_alu with hand-computed expectations.
module tb_vector_alu;
  import vector_alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [63:0] rA_64bit_val;
  logic [63:0] rB_64bit_val;
  logic [5:0]  R_ins;
  logic [5:0]  Op_code;
  logic [1:0]  WW;
  logic [63:0] ALU_out;

  int checks;
  int errors;

  vector_alu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rA_64bit_val (rA_64bit_val),
    .rB_64bit_val (rB_64bit_val),
    .R_ins        (R_ins),
    .Op_code      (Op_code),
    .WW           (WW),
    .ALU_out      (ALU_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply(input logic [5:0] op, input logic [5:0] fn, input logic [1:0] ww,
                       input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    Op_code      = op;
    R_ins        = fn;
    WW           = ww;
    rA_64bit_val = a;
    rB_64bit_val = b;
  endtask

  task automatic check(input string tag, input logic [63:0] exp);
    checks++;
    assert (ALU_out === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, ALU_out, exp);
    end
  endtask

  task automatic run(input string tag, input logic [5:0] fn, input logic [1:0] ww,
                     input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
    apply(OP_VECTOR, fn, ww, a, b);
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;

    // Reset holds the output at zero even with a nonzero op presented.
    apply(OP_VECTOR, FN_VNOT, W64, 64'h0, 64'h0);
    @(posedge clk); #1;
    check("reset", 64'h0);

    // First result appears on the edge after release.
    apply(OP_VECTOR, FN_VAND, W64, 64'd15, 64'd14);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("vand", 64'hE);

    run("vor",  FN_VOR,  W64, 64'd15, 64'd14, 64'hF);
    run("vxor", FN_VXOR, W64, 64'd15, 64'd14, 64'h1);
    run("vnot", FN_VNOT, W64, 64'h0,  64'h0,  64'hFFFFFFFF_FFFFFFFF);
    run("vmov", FN_VMOV, W8,  64'h12345678_9ABCDEF0, 64'h0, 64'h12345678_9ABCDEF0);

    apply(6'b000000, FN_VNOT, W64, 64'h0, 64'h0);
    @(posedge clk); #1;
    check("bad_opcode", 64'h0);
    run("bad_fn", 6'b010011, W64, 64'hFFFF, 64'hFFFF, 64'h0);

    run("vadd_w8",  FN_VADD, W8,  64'hFFFFFFFF_FFFFFFFF, 64'h00000000_11111111, 64'hFFFFFFFF_10101010);
    run("vadd_w16", FN_VADD, W16, 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_11111111, 64'hFFFFFFFF_11101110);
    run("vadd_w32", FN_VADD, W32, 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_11111111, 64'hFFFFFFFF_11111110);
    run("vadd_w64", FN_VADD, W64, 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_11111111, 64'h00000000_11111110);
    run("vsub_w8",  FN_VSUB, W8,  64'h0, 64'h01010101_01010101, 64'hFFFFFFFF_FFFFFFFF);

    run("vmuleu", FN_VMULEU, W16, 64'hFF000000_FFFFFFFF, 64'h00020000_000F0001, 64'h0001FE00_000EFFF1);
    run("vmulou", FN_VMULOU, W16, 64'hFF000000_FFFFFFFF, 64'h00020000_000F0001, 64'h00000000_0000FFFF);
    run("vmuleu_w64", FN_VMULEU, W64, 64'hFFFF, 64'hFFFF, 64'h0);
    run("vsqeu_w32", FN_VSQEU, W32, 64'h00000003_FFFFFFFF, 64'h0, 64'h00000000_00000009);
    run("vsqou_w32", FN_VSQOU, W32, 64'h00000003_FFFFFFFF, 64'h0, 64'hFFFFFFFE_00000001);
    run("vsqeu_w64", FN_VSQEU, W64, 64'h3, 64'h0, 64'h0);

    run("vsqrt_w8",  FN_VSQRT, W8,  64'hFF01FFFF_10040001, 64'h0, 64'h0F010F0F_04020001);
    run("vsqrt_w16", FN_VSQRT, W16, 64'h00000640_00040001, 64'h0, 64'h00000028_00020001);

    run("vsra_w16",  FN_VSRA,  W16, 64'hF0E1F2A2_01010101, 64'h00030003_00030003, 64'hFE1CFE54_00200020);
    run("vsll_w32",  FN_VSLL,  W32, 64'h00000001_80000001, 64'h0000001F_00000021, 64'h80000000_00000002);
    run("vsrl_w8",   FN_VSRL,  W8,  64'h80808080_80808080, 64'h07000102_03040506, 64'h01804020_10080402);
    run("vrtth_w64", FN_VRTTH, W64, 64'hFFFFFFFF_00000000, 64'h0, 64'h00000000_FFFFFFFF);
    run("vrtth_w8",  FN_VRTTH, W8,  64'h12345678_9ABCDEF0, 64'h0, 64'h21436587_A9CBED0F);

    run("vdiv",       FN_VDIV, W64, 64'd102, 64'd10, 64'hA);
    run("vmod",       FN_VMOD, W64, 64'd102, 64'd10, 64'h2);
    run("vdiv_zero",  FN_VDIV, W64, 64'd102, 64'd0,  64'h0);
    run("vmod_zero",  FN_VMOD, W64, 64'd102, 64'd0,  64'h0);
    run("vdiv_w16",   FN_VDIV, W16, 64'h0064_0007_FFFF_0010, 64'h000A_0000_0010_0003, 64'h000A_0000_0FFF_0005);
    run("vmod_w16",   FN_VMOD, W16, 64'h0064_0007_FFFF_0010, 64'h000A_0000_0010_0003, 64'h0000_0000_000F_0001);

    // Back-to-back issue: output holds until the sampling edge, then updates.
    run("b2b_div", FN_VDIV, W64, 64'd102, 64'd10, 64'hA);
    apply(OP_VECTOR, FN_VMOD, W64, 64'd102, 64'd10);
    check("b2b_hold_div", 64'hA);
    @(posedge clk); #1;
    check("b2b_mod", 64'h2);
    apply(OP_VECTOR, FN_VADD, W8, 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_11111111);
    check("b2b_hold_mod", 64'h2);
    @(posedge clk); #1;
    check("b2b_add", 64'hFFFFFFFF_10101010);

    // Reset takes priority over an operation in flight.
    apply(OP_VECTOR, FN_VNOT, W64, 64'h0, 64'h0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("reset_priority", 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_release", 64'hFFFFFFFF_FFFFFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_alu.md
# vector_alu

Registered 64-bit SIMD integer ALU for the vector execution stage. It applies one R-type vector operation, selected by a function code, to two 64-bit register operands. The operands are split into lanes of 8, 16, 32 or 64 bits according to a width field. The result is presented one clock after the operands are sampled.

## Interface
- No parameters. Bit 0 is the MSB throughout (big-endian numbering). Lane 0 is the most-significant lane.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `rA_64bit_val` in 64: operand A.
- `rB_64bit_val` in 64: operand B.
- `R_ins` in 6: function code.
- `Op_code` in 6: primary opcode. Only 6'b101010 (vector R-type) is executed.
- `WW` in 2: lane width. 00 = 8 bits, 01 = 16, 10 = 32, 11 = 64.
- `ALU_out` out 64: registered result.

## Operation
All arithmetic is unsigned and modulo lane width, except VSRA.

Bitwise functions (lane width irrelevant):
- 000001 VAND: A & B.
- 000010 VOR: A | B.
- 000011 VXOR: A ^ B.
- 000100 VNOT: ~A.
- 000101 VMOV: A.

Add, subtract, multiply:
- 000110 VADD: per-lane A + B, wraps.
- 000111 VSUB: per-lane A − B, wraps.
- 001000 VMULEU: even lanes (0, 2, …) of A × B.
  - Each product is double width and occupies the even/odd lane pair.
- 001001 VMULOU: same as VMULEU, using the odd lanes.
- WW = 11 with VMULEU/VMULOU gives 0.

Shifts and rotate:
- 001010 VSLL, 001011 VSRL, 001100 VSRA: per-lane shift of A.
  - Shift amount is the low log2(w) bits of the corresponding B lane.
  - VSRA replicates the lane MSB.
- 001101 VRTTH: rotate each lane by w/2, i.e. swap its upper and lower halves.
  - For WW = 00 the nibbles of each byte are swapped.

Divide and modulo:
- 001110 VDIV: per-lane A / B, floor.
- 001111 VMOD: per-lane A % B.
- A lane with divisor 0 gives 0 in that lane.

Square and square root:
- 010000 VSQEU: even lanes of A squared, double width, same packing as VMULEU.
- 010001 VSQOU: same as VSQEU, using the odd lanes.
- WW = 11 with VSQEU/VSQOU gives 0.
- 010010 VSQRT: per-lane floor(sqrt(A)), zero-extended into the lane.

Default cases:
- Any other R_ins, or Op_code ≠ 101010, produces 0.

## Timing
- Result is computed combinationally from the inputs and registered on the rising clk edge.
- Latency is 1 cycle.
- Throughput is one operation per cycle. There is no handshake and no stall.
- A new operation may be issued every cycle and never corrupts the previous result.
- `rst_n` = 0 at a clk edge sets `ALU_out` = 0. This takes priority over any operation in flight.
- The first result after reset appears on the edge after release.
- Inputs that change mid-cycle matter only at the sampling edge.

## Structure
- Shared package `vector_alu_pkg` holds:
  - the opcode constant OP_VECTOR = 6'b101010;
  - the function codes FN_VAND … FN_VSQRT;
  - the width codes W8/W16/W32/W64.
- One sub-module: `vector_alu_isqrt`, a combinational 64-bit floor integer square root.
  - It is instantiated per lane-width slice, or time-shared through generate loops.
- The remaining logic is lane loops in the top module.

## Test plan
- **Reset and bitwise:**
  - rst_n = 0 -> ALU_out = 0.
  - VAND 15, 14 -> 0xE. VOR -> 0xF. VXOR -> 0x1.
  - VNOT 0 -> all ones.
  - Op_code 000000 -> 0.
- **VADD** with A = FFFFFFFF_FFFFFFFF, B = 00000000_11111111:
  - WW = 00 -> FFFFFFFF_10101010.
  - WW = 01 -> FFFFFFFF_11101110.
  - WW = 10 -> FFFFFFFF_11111110.
  - WW = 11 -> 00000000_11111110.
- **Multiply** with A = FF000000_FFFFFFFF, B = 00020000_000F0001, WW = 01:
  - VMULEU -> 0001FE00_000EFFF1.
  - VMULOU -> 00000000_0000FFFF.
- **VSQRT:**
  - WW = 00, A = FF01FFFF_10040001 -> 0F010F0F_04020001.
  - WW = 01, A = 00000640_00040001 -> 00000028_00020001.
- **Shift and rotate:**
  - VSRA WW = 01, A = F0E1F2A2_01010101, B = 00030003_00030003 -> FE1CFE54_00200020.
  - VRTTH WW = 11, A = FFFFFFFF_00000000 -> 00000000_FFFFFFFF.
- **Divide and modulo**, WW = 11, A = 102, B = 10:
  - VDIV -> 0xA.
  - VMOD -> 0x2.
  - B = 0 -> 0.
  - Back-to-back issue: each result appears exactly one cycle after its operands.
